// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants, used by fetch, decode and execute.
package fetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INSN_BYTES = 4;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
  } fetch_pkt_t;

  // Fall-through PC; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSN_BYTES);
  endfunction

endpackage

// File: rtl/branch_mispredict_check.sv
// Compares a resolved branch against its carried prediction and yields the
// corrected fetch PC.
module branch_mispredict_check
  import fetch_pkg::*;
(
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            mispredict_c,
  output logic [XLEN-1:0] correct_pc_c
);

  always_comb begin
    mispredict_c = 1'b0;
    correct_pc_c = next_seq_pc(ex_pc);
    if (ex_taken) begin
      correct_pc_c = ex_target;
    end
    // Wrong direction, or right direction to the wrong place.
    if (ex_valid) begin
      if (ex_taken != ex_pred_taken) begin
        mispredict_c = 1'b1;
      end else if (ex_taken && (ex_target != ex_pred_target)) begin
        mispredict_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage next-PC generator: drives the BTB lookup, applies predicted and
// resolved redirects, emits decode packets and BTB update strobes.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            fpc_clk,
  input  logic            fpc_reset_n,
  input  logic            fpc_stall,
  output logic [XLEN-1:0] fpc_btb_pc,
  input  logic            fpc_btb_hit,
  input  logic [XLEN-1:0] fpc_btb_target,
  input  logic            fpc_ex_valid,
  input  logic [XLEN-1:0] fpc_ex_pc,
  input  logic            fpc_ex_taken,
  input  logic [XLEN-1:0] fpc_ex_target,
  input  logic            fpc_ex_pred_taken,
  input  logic [XLEN-1:0] fpc_ex_pred_target,
  output logic            fpc_if_valid,
  output logic [XLEN-1:0] fpc_if_pc,
  output logic            fpc_if_pred_taken,
  output logic [XLEN-1:0] fpc_if_pred_target,
  output logic            fpc_flush,
  output logic            fpc_btb_write,
  output logic            fpc_btb_branch_taken,
  output logic [XLEN-1:0] fpc_btb_new_pc,
  output logic [XLEN-1:0] fpc_btb_data
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] prev_pc_q;
  logic            prev_valid_q;
  fetch_pkt_t      pkt_q;
  logic            flush_q;
  logic            btb_write_q;
  logic            btb_taken_q;
  logic [XLEN-1:0] btb_new_pc_q;
  logic [XLEN-1:0] btb_data_q;

  logic            mispredict_c;
  logic [XLEN-1:0] correct_pc_c;

  branch_mispredict_check u_mp_check (
    .ex_valid       (fpc_ex_valid),
    .ex_pc          (fpc_ex_pc),
    .ex_taken       (fpc_ex_taken),
    .ex_target      (fpc_ex_target),
    .ex_pred_taken  (fpc_ex_pred_taken),
    .ex_pred_target (fpc_ex_pred_target),
    .mispredict_c   (mispredict_c),
    .correct_pc_c   (correct_pc_c)
  );

  // While stalled, re-present prev_pc so the next BTB result still matches it.
  assign fpc_btb_pc = fpc_stall ? prev_pc_q : pc_q;

  // PC pipeline and decode packet: mispredict > stall > BTB redirect > sequential.
  always_ff @(posedge fpc_clk) begin
    if (!fpc_reset_n) begin
      pc_q         <= RESET_VECTOR;
      prev_pc_q    <= '0;
      prev_valid_q <= 1'b0;
      pkt_q        <= '0;
      flush_q      <= 1'b0;
    end else if (mispredict_c) begin
      pc_q         <= correct_pc_c;
      prev_valid_q <= 1'b0;
      pkt_q.valid  <= 1'b0;
      flush_q      <= 1'b1;
    end else begin
      flush_q <= 1'b0;
      if (!fpc_stall) begin
        if (prev_valid_q && fpc_btb_hit) begin
          pkt_q        <= '{valid: 1'b1, pc: prev_pc_q, pred_taken: 1'b1,
                            pred_target: fpc_btb_target};
          pc_q         <= fpc_btb_target;
          prev_valid_q <= 1'b0;
        end else begin
          pkt_q        <= '{valid: prev_valid_q, pc: prev_pc_q, pred_taken: 1'b0,
                            pred_target: next_seq_pc(prev_pc_q)};
          prev_pc_q    <= pc_q;
          prev_valid_q <= 1'b1;
          pc_q         <= next_seq_pc(pc_q);
        end
      end
    end
  end

  // BTB training strobe, one per resolved branch regardless of stall or flush.
  always_ff @(posedge fpc_clk) begin
    if (!fpc_reset_n) begin
      btb_write_q  <= 1'b0;
      btb_taken_q  <= 1'b0;
      btb_new_pc_q <= '0;
      btb_data_q   <= '0;
    end else begin
      btb_write_q <= fpc_ex_valid;
      if (fpc_ex_valid) begin
        btb_taken_q  <= fpc_ex_taken;
        btb_new_pc_q <= fpc_ex_pc;
        btb_data_q   <= fpc_ex_target;
      end
    end
  end

  assign fpc_if_valid         = pkt_q.valid;
  assign fpc_if_pc            = pkt_q.pc;
  assign fpc_if_pred_taken    = pkt_q.pred_taken;
  assign fpc_if_pred_target   = pkt_q.pred_target;
  assign fpc_flush            = flush_q;
  assign fpc_btb_write        = btb_write_q;
  assign fpc_btb_branch_taken = btb_taken_q;
  assign fpc_btb_new_pc       = btb_new_pc_q;
  assign fpc_btb_data         = btb_data_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus random
// traffic against a queue-based behavioural model with a table-driven BTB.
module tb_fetch_pc_unit;

  localparam logic [31:0] RV = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n, stall, btb_hit, ex_valid, ex_taken, ex_pred_taken;
  logic [31:0] btb_target, ex_pc, ex_target, ex_pred_target;
  logic [31:0] btb_pc, if_pc, if_pred_target, btb_new_pc, btb_data;
  logic        if_valid, if_pred_taken, flush, btb_write, btb_taken;

  always #5 clk = ~clk;

  fetch_pc_unit #(.RESET_VECTOR(RV)) dut (
    .fpc_clk              (clk),
    .fpc_reset_n          (rst_n),
    .fpc_stall            (stall),
    .fpc_btb_pc           (btb_pc),
    .fpc_btb_hit          (btb_hit),
    .fpc_btb_target       (btb_target),
    .fpc_ex_valid         (ex_valid),
    .fpc_ex_pc            (ex_pc),
    .fpc_ex_taken         (ex_taken),
    .fpc_ex_target        (ex_target),
    .fpc_ex_pred_taken    (ex_pred_taken),
    .fpc_ex_pred_target   (ex_pred_target),
    .fpc_if_valid         (if_valid),
    .fpc_if_pc            (if_pc),
    .fpc_if_pred_taken    (if_pred_taken),
    .fpc_if_pred_target   (if_pred_target),
    .fpc_flush            (flush),
    .fpc_btb_write        (btb_write),
    .fpc_btb_branch_taken (btb_taken),
    .fpc_btb_new_pc       (btb_new_pc),
    .fpc_btb_data         (btb_data)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: next PC to issue, PCs awaiting their BTB answer,
  // last accepted packet and last training strobe.
  logic [31:0] m_pc;
  logic [31:0] m_pend[$];
  logic        m_pkt_valid, m_pkt_pt, m_pkt_known;
  logic [31:0] m_pkt_pc, m_pkt_tgt;
  logic        m_flush, m_wr, m_wr_taken;
  logic [31:0] m_wr_pc, m_wr_data;
  logic [31:0] btb_tab[logic [31:0]];
  logic [31:0] last_pres = 32'hDEAD_0001;
  bit          rnd_hits = 1'b0;
  logic [31:0] seen[$];

  task automatic step();
    logic        hit_v, mp, pres_known;
    logic [31:0] tgt_v, pres;
    @(negedge clk);
    if (btb_tab.exists(last_pres)) begin
      hit_v = 1'b1;
      tgt_v = btb_tab[last_pres];
    end else if (rnd_hits && $urandom_range(7) == 0) begin
      hit_v = 1'b1;
      tgt_v = $urandom_range(1023) & 32'hFFFF_FFFC;
    end else begin
      hit_v = 1'b0;
      tgt_v = $urandom;
    end
    btb_hit    = hit_v;
    btb_target = tgt_v;
    #1;
    pres_known = !stall || (m_pend.size() != 0);
    pres       = stall ? ((m_pend.size() != 0) ? m_pend[0] : 32'hDEAD_0001) : m_pc;
    if (rst_n && pres_known) check_val("btb_pc", btb_pc, pres);
    @(posedge clk);
    if (!rst_n) begin
      m_pc = RV;
      m_pend.delete();
      {m_pkt_valid, m_pkt_pt, m_pkt_pc, m_pkt_tgt} = '0;
      m_pkt_known = 1'b1;
      {m_flush, m_wr, m_wr_taken, m_wr_pc, m_wr_data} = '0;
    end else begin
      m_wr = ex_valid;
      if (ex_valid) begin
        m_wr_taken = ex_taken;
        m_wr_pc    = ex_pc;
        m_wr_data  = ex_target;
      end
      mp = ex_valid && ((ex_taken != ex_pred_taken) ||
                        (ex_taken && ex_pred_taken && ex_target != ex_pred_target));
      m_flush = mp;
      if (mp) begin
        m_pc = ex_taken ? ex_target : ex_pc + 32'd4;
        m_pend.delete();
        m_pkt_valid = 1'b0;
      end else if (!stall) begin
        if (m_pend.size() != 0 && hit_v) begin
          {m_pkt_valid, m_pkt_pc, m_pkt_pt, m_pkt_tgt} = {1'b1, m_pend[0], 1'b1, tgt_v};
          m_pkt_known = 1'b1;
          m_pc = tgt_v;
          m_pend.delete();
        end else begin
          if (m_pend.size() != 0) begin
            {m_pkt_valid, m_pkt_pc, m_pkt_pt, m_pkt_tgt} = {1'b1, m_pend[0], 1'b0, m_pend[0] + 32'd4};
            m_pkt_known = 1'b1;
          end else begin
            m_pkt_valid = 1'b0;
            m_pkt_known = 1'b0;
          end
          m_pend.delete();
          m_pend.push_back(m_pc);
          m_pc = m_pc + 32'd4;
        end
      end
    end
    last_pres = pres_known ? pres : 32'hDEAD_0001;
    #1;
    if (rst_n && !stall && if_valid) seen.push_back(if_pc);
    check_val("if_valid", 32'(if_valid), 32'(m_pkt_valid));
    check_val("flush", 32'(flush), 32'(m_flush));
    check_val("btb_write", 32'(btb_write), 32'(m_wr));
    check_val("btb_taken", 32'(btb_taken), 32'(m_wr_taken));
    check_val("btb_new_pc", btb_new_pc, m_wr_pc);
    check_val("btb_data", btb_data, m_wr_data);
    if (m_pkt_known) begin
      check_val("if_pc", if_pc, m_pkt_pc);
      check_val("if_pred_taken", 32'(if_pred_taken), 32'(m_pkt_pt));
      check_val("if_pred_target", if_pred_target, m_pkt_tgt);
    end
  endtask

  task automatic check_stream(input string tag, input logic [31:0] exp[$]);
    check_val({tag, "_len"}, 32'(seen.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < seen.size(); i++) check_val(tag, seen[i], exp[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] pc, input logic tk,
                        input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
    ex_valid = v; ex_pc = pc; ex_taken = tk; ex_target = tgt;
    ex_pred_taken = ptk; ex_pred_target = ptgt;
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; btb_hit = 1'b0; btb_target = '0;
    set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    btb_tab[32'h108] = 32'h200;

    // Sequential start, then a predicted-taken redirect 108 -> 200.
    do_reset();
    check_val("rst_if_valid", 32'(if_valid), 32'h0);
    check_val("rst_if_pc", if_pc, 32'h0);
    seen.delete();
    step();
    step();
    check_val("first_pkt_valid", 32'(if_valid), 32'h1);
    check_val("first_pkt_pc", if_pc, RV);
    repeat (5) step();
    check_stream("seq_redirect", '{32'h100, 32'h104, 32'h108, 32'h200, 32'h204});

    // Stall while the BTB answer for 108 is pending.
    do_reset();
    seen.delete();
    repeat (3) step();
    stall = 1'b1;
    repeat (3) step();
    check_val("stall_btb_pc", btb_pc, 32'h108);
    stall = 1'b0;
    repeat (4) step();
    check_stream("stall_redirect", '{32'h100, 32'h104, 32'h108, 32'h200, 32'h204});

    // Taken branch predicted not-taken.
    set_ex(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 32'h0);
    step();
    set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_val("mp_flush", 32'(flush), 32'h1);
    check_val("mp_wr", 32'(btb_write), 32'h1);
    check_val("mp_wr_pc", btb_new_pc, 32'h40);
    check_val("mp_wr_data", btb_data, 32'h80);
    seen.delete();
    repeat (3) step();
    check_val("mp_flush_pulse", 32'(flush), 32'h0);
    check_stream("mp_resume", '{32'h80, 32'h84});

    // Mispredict together with stall and a pending BTB hit.
    do_reset();
    repeat (3) step();
    stall = 1'b1;
    set_ex(1'b1, 32'h500, 1'b0, 32'h900, 1'b1, 32'h900);
    step();
    check_val("coinc_flush", 32'(flush), 32'h1);
    stall = 1'b0;
    set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    seen.delete();
    repeat (3) step();
    check_stream("coinc_resume", '{32'h504, 32'h508});

    // Wrap at the top of the address space, then reset mid-stream.
    set_ex(1'b1, 32'hFFFF_FFF8, 1'b0, 32'h1234, 1'b1, 32'h1234);
    step();
    set_ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    seen.delete();
    repeat (3) step();
    check_stream("wrap", '{32'hFFFF_FFFC, 32'h0});
    rst_n = 1'b0;
    step();
    check_val("midrst_if_valid", 32'(if_valid), 32'h0);
    check_val("midrst_if_pc", if_pc, 32'h0);
    check_val("midrst_pred_target", if_pred_target, 32'h0);
    check_val("midrst_btb_data", btb_data, 32'h0);
    rst_n = 1'b1;

    // Random traffic.
    rnd_hits = 1'b1;
    btb_tab[32'h120] = 32'h100;
    btb_tab[32'h200] = 32'h108;
    btb_tab[32'h13C] = 32'h3F0;
    for (int i = 0; i < 2000; i++) begin
      rst_n = ($urandom_range(149) != 0);
      stall = ($urandom_range(4) == 0);
      if ($urandom_range(5) == 0) begin
        ex_valid       = 1'b1;
        ex_pc          = $urandom_range(1023) & 32'hFFFF_FFFC;
        ex_taken       = 1'($urandom_range(1));
        ex_target      = $urandom_range(1023) & 32'hFFFF_FFFC;
        ex_pred_taken  = ($urandom_range(2) == 0) ? ~ex_taken : ex_taken;
        ex_pred_target = ($urandom_range(1) == 0) ? ex_target : ($urandom_range(1023) & 32'hFFFF_FFFC);
      end else begin
        ex_valid = 1'b0;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
